// File: rtl/panel_display_pkg.sv
// Shared constants, frame phase type and the hex-digit to seven-segment encoder
// for the front-panel display driver.
package panel_display_pkg;

  localparam int LED_BITS = 16;
  localparam int SEG_BITS = 32;

  typedef enum logic [0:0] {
    PH_SHIFT = 1'b0,
    PH_LATCH = 1'b1
  } frame_phase_t;

  // Segment byte layout is {dp,g,f,e,d,c,b,a}, 1 = lit; dp is never driven.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
    logic [7:0] seg;
    seg = 8'h00;
    case (nibble)
      4'h0: seg = 8'h3F;
      4'h1: seg = 8'h06;
      4'h2: seg = 8'h5B;
      4'h3: seg = 8'h4F;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'h6D;
      4'h6: seg = 8'h7D;
      4'h7: seg = 8'h07;
      4'h8: seg = 8'h7F;
      4'h9: seg = 8'h6F;
      4'hA: seg = 8'h77;
      4'hB: seg = 8'h7C;
      4'hC: seg = 8'h39;
      4'hD: seg = 8'h5E;
      4'hE: seg = 8'h79;
      4'hF: seg = 8'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/frame_serializer.sv
// Serialises a WIDTH-bit word MSB first, one bit per tick, followed by a
// one-tick latch period; the frame (WIDTH+1 ticks) repeats back-to-back.
module frame_serializer
  import panel_display_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] word,
  output logic             data,
  output logic             latch,
  output logic             load
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  frame_phase_t     phase_reg, phase_next;
  logic [BIT_W-1:0] bit_reg, bit_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic             data_reg, data_next;
  logic             latch_reg, latch_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_reg <= PH_SHIFT;
      bit_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= 1'b0;
      latch_reg <= 1'b0;
    end else begin
      phase_reg <= phase_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      latch_reg <= latch_next;
    end
  end

  // All state, including the pin registers, only moves on a tick edge, so the
  // pins change exactly at period starts.
  always_comb begin
    phase_next = phase_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    latch_next = latch_reg;
    load       = 1'b0;
    if (tick) begin
      case (phase_reg)
        PH_SHIFT: begin
          latch_next = 1'b0;
          if (bit_reg == '0) begin
            // First bit goes straight from the input; the rest waits in shift_reg.
            load       = 1'b1;
            data_next  = word[WIDTH-1];
            shift_next = {word[WIDTH-2:0], 1'b0};
          end else begin
            data_next  = shift_reg[WIDTH-1];
            shift_next = {shift_reg[WIDTH-2:0], 1'b0};
          end
          if (bit_reg == LAST_BIT) begin
            bit_next   = '0;
            phase_next = PH_LATCH;
          end else begin
            bit_next = bit_reg + BIT_W'(1);
          end
        end
        PH_LATCH: begin
          data_next  = 1'b0;
          latch_next = 1'b1;
          phase_next = PH_SHIFT;
        end
        default: phase_next = PH_SHIFT;
      endcase
    end
  end

  assign data  = data_reg;
  assign latch = latch_reg;

endmodule

// File: rtl/panel_display_driver.sv
// Front-panel LED bar and 4-digit seven-segment serial driver with a shared
// shift clock. Build option DISP_LEADING_BLANK_EN blanks leading zero digits.
module panel_display_driver
  import panel_display_pkg::*;
#(
  parameter int TICK_DIV = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] led_in,
  input  logic [15:0] seg_bin,
  output logic        ps_clk,
  output logic        led_data,
  output logic        led_latch,
  output logic        seg_data,
  output logic        seg_latch
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TICK_DIV / 2);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ps_clk_reg, ps_clk_next;
  logic             tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg    <= '0;
      ps_clk_reg <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      ps_clk_reg <= ps_clk_next;
    end
  end

  // ps_clk is registered from the count, so it falls on the same edge that
  // the serializers update their pins (the tick edge, count 0).
  always_comb begin
    tick        = (cnt_reg == '0);
    cnt_next    = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_W'(1);
    ps_clk_next = (cnt_reg >= CNT_HALF);
  end

  assign ps_clk = ps_clk_reg;

  logic [3:0]          digit    [4];
  logic [7:0]          seg_byte [4];
  logic [3:0]          blank;
  logic [SEG_BITS-1:0] seg_word;

  always_comb begin
    blank = 4'b0000;
`ifdef DISP_LEADING_BLANK_EN
    // Blanking propagates from the leftmost digit; d0 always shows.
    blank[3] = (digit[3] == 4'h0);
    for (int i = 2; i >= 1; i--) begin
      blank[i] = blank[i+1] && (digit[i] == 4'h0);
    end
`endif
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign digit[gi]              = seg_bin[4*gi +: 4];
      assign seg_byte[gi]           = blank[gi] ? 8'h00 : hex_to_seg(digit[gi]);
      assign seg_word[8*gi +: 8]    = seg_byte[gi];
    end
  endgenerate

  logic led_load, seg_load;

  frame_serializer #(
    .WIDTH(LED_BITS)
  ) u_led_ser (
    .clk  (clk),
    .reset(reset),
    .tick (tick),
    .word (led_in),
    .data (led_data),
    .latch(led_latch),
    .load (led_load)
  );

  frame_serializer #(
    .WIDTH(SEG_BITS)
  ) u_seg_ser (
    .clk  (clk),
    .reset(reset),
    .tick (tick),
    .word (seg_word),
    .data (seg_data),
    .latch(seg_latch),
    .load (seg_load)
  );

  // Frame-start strobes are kept as named nets for probing only.
  logic load_probe_unused;
  assign load_probe_unused = led_load ^ seg_load;

endmodule

// File: tb/tb_panel_display_driver.sv
// Scoreboard bench for panel_display_driver: expected per-period pin values are
// queued by the stimulus and compared by a monitor at each ps_clk rising edge.
module tb_panel_display_driver;

  localparam int TD = 10;

  localparam logic [31:0] SEG_12AF = 32'h065B7771;
  localparam logic [31:0] SEG_3456 = 32'h4F666D7D;
  localparam logic [31:0] SEG_C9E0 = 32'h396F793F;
`ifdef DISP_LEADING_BLANK_EN
  localparam logic [31:0] SEG_0040 = 32'h0000663F;
`else
  localparam logic [31:0] SEG_0040 = 32'h3F3F663F;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] led_in;
  logic [15:0] seg_bin;
  logic        ps_clk, led_data, led_latch, seg_data, seg_latch;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  panel_display_driver #(
    .TICK_DIV(TD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .led_in   (led_in),
    .seg_bin  (seg_bin),
    .ps_clk   (ps_clk),
    .led_data (led_data),
    .led_latch(led_latch),
    .seg_data (seg_data),
    .seg_latch(seg_latch)
  );

  logic [1:0] led_q[$];
  logic [1:0] seg_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int rise_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Per-period expectation is {latch, data}.
  task automatic push_led(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) led_q.push_back((i < 16) ? {1'b0, v[15-i]} : 2'b10);
  endtask

  task automatic push_seg(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) seg_q.push_back((i < 32) ? {1'b0, w[31-i]} : 2'b10);
  endtask

  task automatic wait_rise(input int target);
    int guard = 0;
    while (rise_cnt < target && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check("reach_period", rise_cnt, target);
  endtask

  // Monitor: ps_clk shape, pin changes only at ps_clk falls, scoreboard pops.
  initial begin
    logic       ps_prev = 1'b0;
    logic [3:0] out_prev = 4'h0;
    logic [3:0] cur;
    logic [1:0] exp;
    int low_run = 0;
    int high_run = 0;
    bit first = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cur = {led_latch, led_data, seg_latch, seg_data};
      if (reset) begin
        rise_cnt = 0;
        low_run  = 0;
        high_run = 0;
        first    = 1'b1;
      end else begin
        if (cur != out_prev && !first) check("edge_align", {ps_prev, ps_clk}, 2'b10);
        if (ps_clk && !ps_prev) begin
          check("ps_low_width", low_run, TD/2);
          high_run = 1;
          $display("period %0d: led latch=%b data=%b  seg latch=%b data=%b",
                   rise_cnt, led_latch, led_data, seg_latch, seg_data);
          rise_cnt++;
          if (led_q.size() > 0) begin
            exp = led_q.pop_front();
            check("led_period", {led_latch, led_data}, exp);
          end
          if (seg_q.size() > 0) begin
            exp = seg_q.pop_front();
            check("seg_period", {seg_latch, seg_data}, exp);
          end
        end else if (!ps_clk && ps_prev) begin
          check("ps_high_width", high_run, TD/2);
          low_run = 1;
        end else if (ps_clk) begin
          high_run++;
        end else begin
          low_run++;
        end
        first = 1'b0;
      end
      ps_prev  = ps_clk;
      out_prev = cur;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    led_in  = 16'h0000;
    seg_bin = 16'h0000;
    repeat (4) @(negedge clk);
    check("reset_state", {ps_clk, led_data, led_latch, seg_data, seg_latch}, 5'b0);

    // Segment 1: 99 periods = 3 seg frames, 5 LED frames + 14 periods.
    push_led(16'h8001, 17);
    push_led(16'h8001, 17);
    push_led(16'h8001, 17);
    push_led(16'h3C5A, 17);
    push_led(16'h3C5A, 17);
    push_led(16'h3C5A, 14);
    push_seg(SEG_12AF, 33);
    push_seg(SEG_12AF, 33);
    push_seg(SEG_0040, 33);
    led_in  = 16'h8001;
    seg_bin = 16'h12AF;
    reset   = 1'b0;

    wait_rise(40);          // mid LED frame 3, period 5
    led_in = 16'h3C5A;
    wait_rise(41);          // mid seg frame 2, period 7
    seg_bin = 16'h0040;
    wait_rise(99);
    check("led_q_drained_1", led_q.size(), 0);
    check("seg_q_drained_1", seg_q.size(), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_clears_1", {ps_clk, led_data, led_latch, seg_data, seg_latch}, 5'b0);

    // Segment 2: reset aborts the LED frame at period 10.
    repeat (3) @(negedge clk);
    push_led(16'hA5C3, 11);
    push_seg(SEG_3456, 11);
    led_in  = 16'hA5C3;
    seg_bin = 16'h3456;
    reset   = 1'b0;
    wait_rise(11);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_abort", {ps_clk, led_data, led_latch, seg_data, seg_latch}, 5'b0);
    repeat (2 * TD) @(negedge clk);
    check("no_latch_in_reset", {led_latch, seg_latch, rise_cnt[1:0]}, 4'b0);

    // Segment 3: clean restart from period 0.
    push_led(16'hFFFF, 17);
    push_led(16'hFFFF, 16);
    push_seg(SEG_C9E0, 33);
    led_in  = 16'hFFFF;
    seg_bin = 16'hC9E0;
    reset   = 1'b0;
    wait_rise(33);
    check("led_q_drained_3", led_q.size(), 0);
    check("seg_q_drained_3", seg_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
